// File: rtl/hier_pkg.sv
// Shared definitions for the hierarchical fan-out node: controller states,
// the architectural ceiling on child count, and a popcount helper used to
// tally how many children completed a handshake in a single cycle.
package hier_pkg;

    // Architectural upper bound on the number of child channels a node may drive
    localparam int MAX_CHILD = 16;

    // Controller states: IDLE accepts a command, SEND drains the pending mask
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Count set bits in a child mask; result fits 0..MAX_CHILD
    function automatic logic [4:0] popcount(input logic [MAX_CHILD-1:0] v);
        logic [4:0] sum;
        sum = '0;
        for (int i = 0; i < MAX_CHILD; i++) begin
            sum = sum + 5'(v[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/hier_fanout_node.sv
// Hierarchical fan-out node: accepts one command at a time from upstream and
// delivers it to one child (unicast) or all children (broadcast). Each child
// handshakes independently; the node stays in SEND until every targeted child
// has taken the payload, counting completed deliveries as it goes.
module hier_fanout_node
    import hier_pkg::*;
#(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [3:0]           in_dest,
    input  logic                 in_bcast,
    output logic [NUM_CHILD-1:0] ch_valid,
    input  logic [NUM_CHILD-1:0] ch_ready,
    output logic [DATA_W-1:0]    ch_data,
    output logic                 busy,
    output logic                 err_dest,
    output logic [CNT_W-1:0]     xfer_cnt
);

    state_t                 state_q, state_d;
    logic [NUM_CHILD-1:0]   pend_q, pend_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic                   destLegal;
    logic [NUM_CHILD-1:0]   loadMask;
    logic [NUM_CHILD-1:0]   handshake;
    logic [4:0]             doneCount;

    // Decode the incoming command into a pending mask and a legality flag
    always_comb begin
        destLegal = in_bcast || ({1'b0, in_dest} < 5'(NUM_CHILD));
        if (in_bcast) begin
            loadMask = '1;
        end else begin
            loadMask = NUM_CHILD'(1) << in_dest;
        end
    end

    // Children that complete a handshake this cycle; ready on an idle lane is ignored
    always_comb begin
        handshake = '0;
        if (state_q == SEND) begin
            handshake = pend_q & ch_ready;
        end
        doneCount = popcount(MAX_CHILD'(handshake));
    end

    // Next-state logic for the accept/drain controller and its datapath registers
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (destLegal) begin
                        data_d  = in_data;
                        pend_d  = loadMask;
                        state_d = SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                pend_d = pend_q & ~handshake;
                cnt_d  = cnt_q + CNT_W'(doneCount);
                if (pend_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any delivery in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs are held low while reset is asserted so nothing handshakes that cycle
    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
        ch_valid = '0;
        if ((state_q == SEND) && !rst) begin
            ch_valid = pend_q;
        end
        ch_data  = data_q;
        busy     = (state_q == SEND);
        err_dest = err_q;
        xfer_cnt = cnt_q;
    end

endmodule

// File: tb/tb_hier_fanout_node.sv
// Directed bench for hier_fanout_node with five children and a 4-bit transfer
// counter, so a short run of deliveries exercises counter wraparound.
module tb_hier_fanout_node;

    localparam int NUM_CHILD = 5;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 4;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data;
    logic [3:0]           in_dest;
    logic                 in_bcast;
    logic [NUM_CHILD-1:0] ch_valid;
    logic [NUM_CHILD-1:0] ch_ready;
    logic [DATA_W-1:0]    ch_data;
    logic                 busy;
    logic                 err_dest;
    logic [CNT_W-1:0]     xfer_cnt;

    int checkCount = 0;
    int errorCount = 0;

    hier_fanout_node #(
        .NUM_CHILD (NUM_CHILD),
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .in_bcast (in_bcast),
        .ch_valid (ch_valid),
        .ch_ready (ch_ready),
        .ch_data  (ch_data),
        .busy     (busy),
        .err_dest (err_dest),
        .xfer_cnt (xfer_cnt)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command on the upstream port
    task automatic applyStimulus(input logic valid, input logic bcast,
                                 input logic [3:0] dest, input logic [DATA_W-1:0] data);
        in_valid = valid;
        in_bcast = bcast;
        in_dest  = dest;
        in_data  = data;
    endtask

    // Per-cycle ready pattern and expected ch_valid for the staggered broadcast
    logic [NUM_CHILD-1:0] bcReady [4];
    logic [NUM_CHILD-1:0] bcValid [4];

    initial begin
        bcReady[0] = 5'b01001; bcValid[0] = 5'b11111;
        bcReady[1] = 5'b01001; bcValid[1] = 5'b10110;
        bcReady[2] = 5'b00000; bcValid[2] = 5'b10110;
        bcReady[3] = 5'b10110; bcValid[3] = 5'b10110;

        rst      = 1'b1;
        ch_ready = '0;
        applyStimulus(1'b1, 1'b1, 4'd0, 8'h77);

        // Reset: outputs forced low even with a command offered
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_ch_valid", 32'(ch_valid), 32'd0);
        checkOutput("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_err_dest", 32'(err_dest), 32'd0);
        checkOutput("rst_ch_data",  32'(ch_data),  32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Unicast to child 2 with every child ready
        ch_ready = 5'b11111;
        applyStimulus(1'b1, 1'b0, 4'd2, 8'hA5);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
        checkOutput("uc_ch_valid", 32'(ch_valid), 32'b00100);
        checkOutput("uc_ch_data",  32'(ch_data),  32'hA5);
        checkOutput("uc_in_ready", 32'(in_ready), 32'd0);
        checkOutput("uc_busy",     32'(busy),     32'd1);
        tick();
        checkOutput("uc_done_ch_valid", 32'(ch_valid), 32'd0);
        checkOutput("uc_done_in_ready", 32'(in_ready), 32'd1);
        checkOutput("uc_done_xfer_cnt", 32'(xfer_cnt), 32'd1);

        // Broadcast with staggered readiness; ready on a cleared lane is ignored
        ch_ready = '0;
        applyStimulus(1'b1, 1'b1, 4'd9, 8'h3C);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
        for (int c = 0; c < 4; c++) begin
            ch_ready = bcReady[c];
            checkOutput($sformatf("bc_busy_%0d", c),     32'(busy),     32'd1);
            checkOutput($sformatf("bc_ch_valid_%0d", c), 32'(ch_valid), 32'(bcValid[c]));
            checkOutput($sformatf("bc_ch_data_%0d", c),  32'(ch_data),  32'h3C);
            tick();
        end
        ch_ready = '0;
        checkOutput("bc_done_busy",     32'(busy),     32'd0);
        checkOutput("bc_done_ch_valid", 32'(ch_valid), 32'd0);
        checkOutput("bc_done_xfer_cnt", 32'(xfer_cnt), 32'd6);

        // Unicast to a child that does not exist is dropped with an error pulse
        ch_ready = 5'b11111;
        applyStimulus(1'b1, 1'b0, 4'd7, 8'hEE);
        checkOutput("ill_in_ready_pre", 32'(in_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
        checkOutput("ill_err_dest",  32'(err_dest), 32'd1);
        checkOutput("ill_ch_valid",  32'(ch_valid), 32'd0);
        checkOutput("ill_in_ready",  32'(in_ready), 32'd1);
        checkOutput("ill_busy",      32'(busy),     32'd0);
        checkOutput("ill_xfer_cnt",  32'(xfer_cnt), 32'd6);
        tick();
        checkOutput("ill_err_clear", 32'(err_dest), 32'd0);

        // Unicast to the highest legal child
        applyStimulus(1'b1, 1'b0, 4'd4, 8'h42);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
        checkOutput("hi_ch_valid", 32'(ch_valid), 32'b10000);
        checkOutput("hi_err_dest", 32'(err_dest), 32'd0);
        tick();
        checkOutput("hi_xfer_cnt", 32'(xfer_cnt), 32'd7);

        // Backpressure: child 1 holds off for ten cycles while upstream changes
        ch_ready = 5'b11101;
        applyStimulus(1'b1, 1'b0, 4'd1, 8'h5A);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd3, 8'hFF);
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("bp_ch_valid_%0d", c), 32'(ch_valid), 32'b00010);
            checkOutput($sformatf("bp_ch_data_%0d", c),  32'(ch_data),  32'h5A);
            checkOutput($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
        ch_ready = 5'b11111;
        tick();
        checkOutput("bp_done_ch_valid", 32'(ch_valid), 32'd0);
        checkOutput("bp_done_xfer_cnt", 32'(xfer_cnt), 32'd8);

        // Reset during a broadcast with three children still pending
        ch_ready = '0;
        applyStimulus(1'b1, 1'b1, 4'd0, 8'h99);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
        ch_ready = 5'b00011;
        tick();
        checkOutput("mr_ch_valid_pend", 32'(ch_valid), 32'b11100);
        checkOutput("mr_xfer_cnt_pend", 32'(xfer_cnt), 32'd10);
        ch_ready = 5'b11111;
        rst = 1'b1;
        #1;
        checkOutput("mr_rst_ch_valid", 32'(ch_valid), 32'd0);
        checkOutput("mr_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mr_ch_valid", 32'(ch_valid), 32'd0);
        checkOutput("mr_xfer_cnt", 32'(xfer_cnt), 32'd0);
        checkOutput("mr_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mr_busy",     32'(busy),     32'd0);

        // Seventeen unicast deliveries wrap the 4-bit counter back to one
        ch_ready = 5'b11111;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 1'b0, 4'(i % NUM_CHILD), 8'(i));
            tick();
            applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
            tick();
            if (i == 15) begin
                checkOutput("wrap_at_16", 32'(xfer_cnt), 32'd0);
            end
        end
        checkOutput("wrap_xfer_cnt", 32'(xfer_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
